// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V width codes, FSM states
// and the request legality rule used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Unsupported width codes, unsigned stores and misaligned H/W are illegal.
  function automatic logic is_illegal(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = |addr_lo;
      F3_BU:   bad = we;
      F3_HU:   bad = we | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: replicates store data and builds byte strobes,
// and selects/extends the addressed lane of a loaded word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rd,
  output logic [3:0]  wstrb,
  output logic [31:0] wd,
  output logic [31:0] rdata
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store steering: strobe shifted to the addressed lane, data replicated.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    wstrb = 4'b0000;
    wd    = 32'h0;
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << addr_lo;
        wd    = {4{wdata[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << addr_lo;
        wd    = {2{wdata[15:0]}};
      end
      2'b10: begin
        wstrb = 4'b1111;
        wd    = wdata;
      end
      default: ;
    endcase
  end

  // Load extraction: pick byte/half lane, then sign- or zero-extend.
  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = rd[7:0];
      2'd1:    ld_byte = rd[15:8];
      2'd2:    ld_byte = rd[23:16];
      default: ld_byte = rd[31:24];
    endcase
    ld_half = addr_lo[1] ? rd[31:16] : rd[15:0];
    case (funct3)
      F3_B:    rdata = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    rdata = {{16{ld_half[15]}}, ld_half};
      F3_W:    rdata = rd;
      F3_BU:   rdata = {24'h0, ld_byte};
      F3_HU:   rdata = {16'h0, ld_half};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one CPU request at a time, performs a single
// word-aligned memory access and returns a one-cycle completion pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1  // 1: registered (BSRAM) read, 0: combinational
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_re,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        capture;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wd;
  logic [31:0] al_rdata;

  lsu_align u_align (
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .wdata   (wdata_q),
    .rd      (mem_rd),
    .wstrb   (al_wstrb),
    .wd      (al_wd),
    .rdata   (al_rdata)
  );

  // State register; reset drops straight to IDLE, abandoning any access.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: asynchronous reset, and non-blocking assignments for all state.
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid)
          state_d = is_illegal(req_we, req_funct3, req_addr[1:0]) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: state_d = (!we_q && MEM_LATENCY == 1) ? S_WAIT : S_RESP;
      S_WAIT:   state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the memory strobes exist only in ACCESS so an
  // asserted reset removes them in the same cycle.
  always_comb begin
    req_ready  = reset_n && (state_q == S_IDLE);
    accept     = (state_q == S_IDLE) && req_valid;
    capture    = !we_q && ((state_q == S_WAIT) ||
                           (state_q == S_ACCESS && MEM_LATENCY == 0));
    mem_re     = (state_q == S_ACCESS) && !we_q;
    mem_wstrb  = ((state_q == S_ACCESS) && we_q) ? al_wstrb : 4'b0000;
    mem_wd     = ((state_q == S_ACCESS) && we_q) ? al_wd : 32'h0;
    mem_a      = (state_q == S_ACCESS || state_q == S_WAIT) ? {addr_q[31:2], 2'b00} : 32'h0;
    resp_valid = (state_q == S_RESP);
    resp_err   = (state_q == S_RESP) && err_q;
    resp_rdata = rdata_q;
  end

  // Request capture on accept and load-data capture at the end of the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= is_illegal(req_we, req_funct3, req_addr[1:0]);
        rdata_q  <= 32'h0;  // stores and errors complete with zero data
      end
      if (capture) rdata_q <= al_rdata;
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, meaning memory read latency in cycles: 1 for BSRAM, 0 for synthesized memory; only values 0 and 1 are legal.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; reset_n  in  1  reset.
REQ-003 SHALL have req_valid  in  1  CPU request present.
REQ-004 SHALL have req_ready  out  1  request accepted on this edge if req_valid=1.
REQ-005 SHALL have req_we  in  1  1=store, 0=load.
REQ-006 SHALL have req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have req_addr  in  32  byte address.
REQ-008 SHALL have req_wdata  in  32  store data, LSB-justified.
REQ-009 SHALL have resp_valid  out  1  single-cycle completion pulse.
REQ-010 SHALL have resp_rdata  out  32  extended load data, valid with resp_valid.
REQ-011 SHALL have resp_err  out  1  misaligned or illegal request, valid with resp_valid.
REQ-012 SHALL have mem_re  out  1, mem_wstrb  out  4, mem_a  out  32, mem_wd  out  32, mem_rd  in  32, forming the memory-side port.

Function
REQ-013 SHALL implement FSM IDLE, ACCESS, WAIT, RESP; req_ready=1 only in IDLE.
REQ-014 SHALL, in IDLE on req_valid, register we/funct3/addr/wdata and go to ACCESS, or to RESP with resp_err=1 if the request is illegal.
REQ-015 SHALL treat as illegal: funct3 011/110/111; store with funct3[2]=1; H/HU with addr[0]=1; W with addr[1:0]!=00.
REQ-016 SHALL perform no memory access (mem_re=0, mem_wstrb=0) for an illegal request.
REQ-017 SHALL drive mem_a={addr[31:2],2'b00}, and mem_re=1 for loads or mem_wstrb nonzero for stores, only while in ACCESS; both SHALL be 0 in every other state.
REQ-018 SHALL steer store data: B -> wstrb=0001<<addr[1:0], wd={4{wdata[7:0]}}; H -> wstrb=0011<<addr[1:0], wd={2{wdata[15:0]}}; W -> wstrb=1111, wd=wdata.
REQ-019 SHALL, with MEM_LATENCY=0, capture mem_rd at the end of ACCESS and go to RESP; with MEM_LATENCY=1, go ACCESS->WAIT, hold mem_a, and capture mem_rd at the end of WAIT.
REQ-020 SHALL extract the load lane selected by addr[1:0] (byte) or addr[1] (half), sign-extend for B/H and zero-extend for BU/HU, and register the result into resp_rdata.
REQ-021 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; stores complete with resp_rdata=0.
REQ-022 SHALL assert resp_valid 2+MEM_LATENCY cycles after the accepting edge for legal loads, 2 cycles for stores, and 1 cycle for illegal requests.
REQ-023 SHALL ignore req_valid outside IDLE; there is no response backpressure.

Reset
REQ-024 SHALL, on reset_n=0 at any time, enter IDLE asynchronously and abandon any in-flight access.
REQ-025 SHALL hold these values during reset: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_re=0, mem_wstrb=0, mem_a=0, mem_wd=0; req_ready SHALL rise in the first cycle after release.
REQ-026 SHALL force mem_wstrb=0 immediately when reset asserts during ACCESS, so that no partial store commits after assertion.

Structure
REQ-027 SHALL place the funct3 encoding constants and the state enum in shared package lsu_pkg.
REQ-028 SHALL isolate store steering and load extraction in a combinational sub-module lsu_align.

Verification
REQ-029 SHALL cover: SB addr=0x103, wdata=0xA5 -> ACCESS wstrb=1000, mem_wd=0xA5A5A5A5, mem_a=0x100, resp_valid 2 cycles after accept.
REQ-030 SHALL cover: LB addr=0x101, mem_rd=0x12348000 -> resp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080 (MEM_LATENCY=1, resp 3 cycles after accept).
REQ-031 SHALL cover: LH addr=0x102, mem_rd=0xBEEF0000 -> resp_rdata=0xFFFFBEEF; repeat with MEM_LATENCY=0 -> resp 2 cycles after accept.
REQ-032 SHALL cover: SW addr=0x102 -> resp_err=1 one cycle after accept, with mem_wstrb=0 and mem_re=0 throughout.
REQ-033 SHALL cover: SW 0xDEADBEEF then LW at the same address against a memory model -> resp_rdata=0xDEADBEEF, and req_valid held high during the busy state is not re-accepted.
REQ-034 SHALL cover: reset_n dropped during ACCESS of a store -> mem_wstrb=0 in the same cycle, memory unchanged, req_ready=1 in the first cycle after release.
